serial_neuron_acc: RTL and testbench
====================================

# serial_neuron_acc

Downstream consumer of the weight-selector stage: takes the serial weight stream (one `data_width` weight per clock, started by a `go` pulse) and multiplies each weight by the matching activation. It accumulates the products over `weight_n` cycles, adds a bias, then applies ReLU, scaling and saturation. The finished neuron output is held behind a valid/ready handshake, and a `freeze` signal stalls the selector while the result is unconsumed.

## Interface
- `weight_n`, 8: weights per neuron; must be ≥ 2.
- `data_width`, 4: width of weights, activations and result.
- `frac_bits`, 2: arithmetic right shift applied after ReLU; must be < `acc_w`.
- `acc_w` (derived localparam): 2*`data_width` + clog2(`weight_n`); 11 at defaults.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `go_in`  in  1  one-cycle start pulse from the selector; weight 0 is valid on `w_in` in the same cycle.
- `w_in`  in  `data_width`  signed weight, two's complement.
- `act_in`  in  `weight_n`*`data_width`  signed activations; activation i occupies bits [i*`data_width` +: `data_width`]; must be stable from `go_in` until `result_valid`.
- `bias_in`  in  2*`data_width`  signed bias; sampled in the FINAL state.
- `result_out`  out  `data_width`  unsigned neuron output.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  downstream accepts the result.
- `freeze_out`  out  1  stall request to the selector.
- `busy`  out  1  high in ACC or FINAL.
- `overrun`  out  1  sticky error flag; set when `go_in` arrives in ACC or FINAL.

## Operation
- States: IDLE, ACC, FINAL, HOLD.
- IDLE:
  - On `go_in`: acc ← w_in*act[0], idx ← 1, go to ACC.
  - Otherwise stay in IDLE.
- ACC, each cycle:
  - acc ← acc + w_in*act[idx], idx ← idx+1.
  - After the product for idx = `weight_n`-1 is accumulated, go to FINAL.
- FINAL (one cycle):
  - s = acc + sign-extended `bias_in`.
  - r = 0 if s < 0, otherwise s >>> `frac_bits`.
  - `result_out` ← min(r, 2^`data_width`-1).
  - `result_valid` ← 1, go to HOLD.
- HOLD: hold `result_out` and `result_valid` stable until `result_ready`.
  - `result_ready` without `go_in`: clear `result_valid`, go to IDLE.
  - `result_ready` and `go_in` in the same cycle: clear `result_valid`, start a new accumulation exactly as IDLE does, go to ACC.
  - `go_in` without `result_ready`: ignored; does not set `overrun`.
- `go_in` in ACC or FINAL: ignored; sets `overrun`.
- Arithmetic:
  - Products are full 2*`data_width` signed values.
  - The accumulator is `acc_w` signed bits and cannot overflow by construction.
- `freeze_out` = `result_valid` & ~`result_ready`. It is combinational from `result_ready`; there is no other combinational input-to-output path.

## Timing
- `go_in` sampled at clock edge E0. Weights are sampled at edges E0 through E(n-1), where n = `weight_n`.
- FINAL is processed at edge E(n), so `result_valid` rises after edge E(n). For n = 8, `result_valid` is first seen 8 cycles after the `go_in` cycle.
- Maximum throughput is one neuron every n+1 cycles when `result_ready` is held high.
- Reset values: `result_out`=0, `result_valid`=0, `busy`=0, `overrun`=0, `freeze_out`=0, state IDLE, acc=0, idx=0.
- Reset asserted mid-accumulation or in HOLD aborts immediately; the partial result is discarded.
- `go_in` arriving on the first edge after reset release is accepted normally.

## Structure
- Shared package `nn_pkg`:
  - state enum (IDLE/ACC/FINAL/HOLD);
  - constant function `clog2`;
  - `acc_w` derivation function, so the selector and later layers size their data identically.
- One combinational sub-module, `relu_sat`: bias add, ReLU, shift and saturation, parameterised by `acc_w`, `data_width` and `frac_bits`.
- The counter, MAC and FSM stay in the top level.

## Test plan
All scenarios use the defaults. Weight stream on `w_in`: 0,2,4,6,8,A,C,E (signed 0,2,4,6,-8,-6,-4,-2).
- `act_in`=32'h11111111, `bias_in`=0: sum is -8 → `result_out`=0, `result_valid` high 8 cycles after `go_in`.
- `act_in`=32'h00001111, `bias_in`=4: 12+4=16, >>>2 → `result_out`=4.
- `act_in`=32'h00007777, `bias_in`=0: 84>>>2=21 → saturates to 15.
- Hold `result_ready` low for 5 cycles after `result_valid`:
  - `freeze_out`=1 and `result_out` stable throughout;
  - a `go_in` during this period is ignored and `overrun` stays 0;
  - raising `result_ready` together with `go_in` starts the next neuron with no idle cycle.
- Pulse `go_in` again 3 cycles into accumulation: `overrun`=1, and the result is unchanged from the single-pulse case.
- Assert `rst` at cycle 4 of accumulation:
  - all outputs go to 0 asynchronously;
  - a fresh `go_in` after release yields the correct result.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared package for the neural-network datapath stages.
// Holds the controller state encoding, a constant clog2, and the
// accumulator width rule. The selector and later layers size their
// arithmetic from the same function, so their widths always agree.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FINAL = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // A full product is 2*dw bits. Summing n of them needs clog2(n) extra bits.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

endpackage

// File: rtl/serial_neuron_acc_if.sv
// Handshake/data bundle between the weight selector, the serial neuron
// accumulator and the downstream result consumer.
//   master : the driving side (selector + consumer). It drives go_in,
//            w_in, act_in, bias_in and result_ready.
//   slave  : the neuron accumulator. It drives result_out, result_valid,
//            freeze_out, busy and overrun.
interface serial_neuron_acc_if #(
  parameter int weight_n   = 8,
  parameter int data_width = 4
);
  logic                           go_in;
  logic [data_width-1:0]          w_in;
  logic [weight_n*data_width-1:0] act_in;
  logic [2*data_width-1:0]        bias_in;
  logic [data_width-1:0]          result_out;
  logic                           result_valid;
  logic                           result_ready;
  logic                           freeze_out;
  logic                           busy;
  logic                           overrun;

  modport master (
    output go_in, w_in, act_in, bias_in, result_ready,
    input  result_out, result_valid, freeze_out, busy, overrun
  );

  modport slave (
    input  go_in, w_in, act_in, bias_in, result_ready,
    output result_out, result_valid, freeze_out, busy, overrun
  );
endinterface

// File: rtl/serial_neuron_acc_relu_sat.sv
// relu_sat: combinational output stage of a neuron.
// It adds the sign-extended bias to the accumulator and applies ReLU.
// It then does an arithmetic right shift by frac_bits and saturates to
// an unsigned data_width result.
//   i_acc    : signed accumulator, acc_w bits
//   i_bias   : signed bias, 2*data_width bits
//   o_result : unsigned result, data_width bits
module relu_sat #(
  parameter int acc_w      = 11,
  parameter int data_width = 4,
  parameter int frac_bits  = 2
) (
  input  logic signed [acc_w-1:0]        i_acc,
  input  logic signed [2*data_width-1:0] i_bias,
  output logic        [data_width-1:0]   o_result
);
  // One guard bit, so the bias add can never wrap, whatever the bias value.
  localparam int S_W = acc_w + 1;

  logic signed [S_W-1:0] w_sum;
  logic signed [S_W-1:0] w_shift;

  assign w_sum   = {i_acc[acc_w-1], i_acc}
                 + {{(S_W-2*data_width){i_bias[2*data_width-1]}}, i_bias};
  assign w_shift = w_sum >>> frac_bits;

  always_comb begin
    o_result = w_shift[data_width-1:0];
    if (w_sum[S_W-1])
      o_result = '0;                        // ReLU
    else if (|w_shift[S_W-1:data_width])
      o_result = '1;                        // non-negative but above range
  end
endmodule

// File: rtl/serial_neuron_acc.sv
// serial_neuron_acc: serial multiply-accumulate neuron.
// It takes one weight per clock from the selector, starting with a go
// pulse. Each weight is multiplied by the matching activation and summed
// over weight_n cycles. The FINAL cycle then adds the bias, applies ReLU,
// shifts and saturates. The result is held behind a valid/ready handshake.
//   clk, rst     : rising-edge clock, async active-high reset
//   bus.go_in    : start pulse; weight 0 is on w_in in the same cycle
//   bus.w_in     : signed weight stream
//   bus.act_in   : packed signed activations, held stable for the whole neuron
//   bus.bias_in  : signed bias, sampled in FINAL
//   bus.result_* : registered result with valid/ready
//   bus.freeze_out : stalls the selector while a result is unconsumed
//   bus.busy     : accumulation in progress (ACC or FINAL)
//   bus.overrun  : sticky flag; set by a go pulse that arrives in ACC or FINAL
module serial_neuron_acc
  import nn_pkg::*;
#(
  parameter int weight_n   = 8,
  parameter int data_width = 4,
  parameter int frac_bits  = 2
) (
  input logic                clk,
  input logic                rst,
  serial_neuron_acc_if.slave bus
);
  localparam int acc_w = acc_width(data_width, weight_n);
  localparam int IDX_W = clog2(weight_n);

  state_e                  r_state;
  logic signed [acc_w-1:0] r_acc;
  logic [IDX_W-1:0]        r_idx;
  logic [data_width-1:0]   r_result;
  logic                    r_valid;
  logic                    r_overrun;

  logic [weight_n-1:0][data_width-1:0] w_act;
  logic [IDX_W-1:0]                    w_sel;
  logic signed [2*data_width-1:0]      w_w_ext;
  logic signed [2*data_width-1:0]      w_a_ext;
  logic signed [2*data_width-1:0]      w_prod;
  logic signed [acc_w-1:0]             w_prod_ext;
  logic [data_width-1:0]               w_final;

  assign w_act = bus.act_in;

  // A start (from IDLE or HOLD) always uses activation 0, and r_idx is 0 then.
  // Forcing the select keeps the start path independent of r_idx.
  assign w_sel = (r_state == ST_ACC) ? r_idx : '0;

  // Sign-extend both operands to the product width, so the multiply is a
  // full signed product.
  assign w_w_ext    = {{data_width{bus.w_in[data_width-1]}}, bus.w_in};
  assign w_a_ext    = {{data_width{w_act[w_sel][data_width-1]}}, w_act[w_sel]};
  assign w_prod     = w_w_ext * w_a_ext;
  assign w_prod_ext = {{(acc_w-2*data_width){w_prod[2*data_width-1]}}, w_prod};

  relu_sat #(
    .acc_w      (acc_w),
    .data_width (data_width),
    .frac_bits  (frac_bits)
  ) u_relu_sat (
    .i_acc    (r_acc),
    .i_bias   (bus.bias_in),
    .o_result (w_final)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_idx     <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.go_in) begin
            r_acc   <= w_prod_ext;
            r_idx   <= IDX_W'(1);
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (bus.go_in) r_overrun <= 1'b1;
          r_acc <= r_acc + w_prod_ext;
          if (r_idx == IDX_W'(weight_n - 1)) begin
            r_idx   <= '0;
            r_state <= ST_FINAL;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_FINAL: begin
          if (bus.go_in) r_overrun <= 1'b1;
          r_result <= w_final;
          r_valid  <= 1'b1;
          r_state  <= ST_HOLD;
        end
        ST_HOLD: begin
          // A go without ready is dropped: the selector is frozen here.
          if (bus.result_ready) begin
            r_valid <= 1'b0;
            if (bus.go_in) begin
              r_acc   <= w_prod_ext;
              r_idx   <= IDX_W'(1);
              r_state <= ST_ACC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.result_out   = r_result;
  assign bus.result_valid = r_valid;
  assign bus.overrun      = r_overrun;
  assign bus.busy         = (r_state == ST_ACC) || (r_state == ST_FINAL);
  assign bus.freeze_out   = r_valid & ~bus.result_ready;
endmodule

// File: tb/tb_serial_neuron_acc.sv
// Bench for serial_neuron_acc: table vectors, hand sequences for
// hold/overrun/reset, and random neurons against an integer model.
module tb_serial_neuron_acc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_neuron_acc_if #(.weight_n(8), .data_width(4)) bus_if ();

  serial_neuron_acc #(.weight_n(8), .data_width(4), .frac_bits(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [7:0]  bias;
    int          exp;
  } vec_t;
  vec_t tbl[4];

  localparam logic [31:0] SPEC_W = 32'hECA86420;  // 0,2,4,6,8,A,C,E

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Neuron model in plain integer arithmetic.
  function automatic int model(input logic [31:0] act, input logic [7:0] bias,
                               input logic [31:0] wv);
    int s;
    int r;
    logic [3:0] wn, an;
    s = $signed(bias);
    for (int i = 0; i < 8; i++) begin
      wn = wv[i*4 +: 4];
      an = act[i*4 +: 4];
      s += int'($signed(wn)) * int'($signed(an));
    end
    if (s < 0) return 0;
    r = s / 4;
    return (r > 15) ? 15 : r;
  endfunction

  // Runs one neuron. go is driven with weight 0 on a negedge. lat counts the
  // rising edges after the edge that sampled go, up to the point where
  // result_valid is first seen. bsy is busy one cycle after go. If xgo is
  // 1..7, a second go is pulsed with that weight. If rel is set, reset is
  // released in the go cycle.
  task automatic run_neuron(input logic [31:0] act, input logic [7:0] bias,
                            input logic [31:0] wv, input logic rdy, input int xgo,
                            input logic rel, output int res, output int lat,
                            output int bsy);
    @(negedge clk);
    bus_if.act_in       = act;
    bus_if.bias_in      = bias;
    bus_if.go_in        = 1'b1;
    bus_if.w_in         = wv[3:0];
    bus_if.result_ready = rdy;
    if (rel) rst = 1'b0;
    bsy = 0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) bsy = int'(bus_if.busy);
      bus_if.go_in = (k == xgo);
      bus_if.w_in  = wv[k*4 +: 4];
    end
    lat = 6;
    do begin
      @(negedge clk);
      bus_if.go_in = 1'b0;
      lat++;
    end while (!bus_if.result_valid && lat < 40);
    res = int'(bus_if.result_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int res, lat, bsy, exp;
    logic [31:0] ra, rw;
    logic [7:0]  rb;

    tbl[0] = '{"act1111_b0",   32'h11111111, 8'h00, 0};
    tbl[1] = '{"act0011_b4",   32'h00001111, 8'h04, 4};
    tbl[2] = '{"act7777_sat",  32'h00007777, 8'h00, 15};
    tbl[3] = '{"actneg1_b0",   32'hFFFFFFFF, 8'h00, 2};

    rst = 1'b1;
    bus_if.go_in = 1'b0;
    bus_if.w_in = '0;
    bus_if.act_in = '0;
    bus_if.bias_in = '0;
    bus_if.result_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid",   int'(bus_if.result_valid), 0);
    chk("reset_result",  int'(bus_if.result_out),   0);
    chk("reset_busy",    int'(bus_if.busy),         0);
    chk("reset_overrun", int'(bus_if.overrun),      0);
    chk("reset_freeze",  int'(bus_if.freeze_out),   0);

    // Table vectors using the spec weight stream.
    for (int t = 0; t < 4; t++) begin
      run_neuron(tbl[t].act, tbl[t].bias, SPEC_W, 1'b1, -1, 1'b0, res, lat, bsy);
      chk({tbl[t].nm, "_result"}, res, tbl[t].exp);
      chk({tbl[t].nm, "_latency"}, lat, 8);
      chk({tbl[t].nm, "_busy"}, bsy, 1);
    end

    // Hold with ready low: freeze, stable result, stray go ignored.
    run_neuron(32'h00001111, 8'h04, SPEC_W, 1'b0, -1, 1'b0, res, lat, bsy);
    chk("hold_first_result", res, 4);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      bus_if.go_in = (j == 2);
      chk("hold_freeze", int'(bus_if.freeze_out), 1);
      chk("hold_valid",  int'(bus_if.result_valid), 1);
      chk("hold_result", int'(bus_if.result_out), 4);
    end
    chk("hold_overrun", int'(bus_if.overrun), 0);
    // Ready and go together: the next neuron starts with no idle cycle.
    run_neuron(32'h00007777, 8'h00, SPEC_W, 1'b1, -1, 1'b0, res, lat, bsy);
    chk("b2b_busy", bsy, 1);
    chk("b2b_latency", lat, 8);
    chk("b2b_result", res, 15);
    chk("b2b_overrun", int'(bus_if.overrun), 0);

    // Second go three cycles into accumulation.
    run_neuron(32'h00001111, 8'h04, SPEC_W, 1'b1, 3, 1'b0, res, lat, bsy);
    chk("ovr_flag", int'(bus_if.overrun), 1);
    chk("ovr_result", res, 4);
    chk("ovr_latency", lat, 8);

    // Reset in cycle 4 of accumulation.
    @(negedge clk);
    bus_if.act_in = 32'h00007777;
    bus_if.bias_in = 8'h00;
    bus_if.go_in = 1'b1;
    bus_if.w_in = SPEC_W[3:0];
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      bus_if.go_in = 1'b0;
      bus_if.w_in = SPEC_W[k*4 +: 4];
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_valid",   int'(bus_if.result_valid), 0);
    chk("arst_result",  int'(bus_if.result_out),   0);
    chk("arst_busy",    int'(bus_if.busy),         0);
    chk("arst_overrun", int'(bus_if.overrun),      0);
    chk("arst_freeze",  int'(bus_if.freeze_out),   0);
    repeat (2) @(negedge clk);
    run_neuron(32'h00001111, 8'h04, SPEC_W, 1'b1, -1, 1'b1, res, lat, bsy);
    chk("post_rst_result", res, 4);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_busy", bsy, 1);

    // Random neurons against the model.
    for (int t = 0; t < 24; t++) begin
      ra = $urandom;
      rw = $urandom;
      rb = 8'($urandom_range(0, 255));
      exp = model(ra, rb, rw);
      run_neuron(ra, rb, rw, 1'b1, -1, 1'b0, res, lat, bsy);
      chk("rand_result", res, exp);
      chk("rand_latency", lat, 8);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
